quest: RTL and testbench
========================

// Module: quest
// PURPOSE
//  Free-running pattern/compare generator.
//  - Keeps a 32-bit cycle counter and an 8-bit Galois LFSR.
//  - Presents four byte lanes A..D derived from them.
//  - Flags on out when lane sum A+B exceeds lane sum C+D.
//  - Used as a self-contained stimulus source: needs only a clock and a reset.
// PARAMETERS
//  CNT_W      32     counter width; counter_value port is CNT_W bits
//  LFSR_SEED  8'hA5  LFSR reset value; 0 is illegal, forced to 8'h01 internally
//  LFSR_TAPS  8'hB8  Galois feedback mask (x^8+x^6+x^5+x^4+1)
// PORTS
//  clk            in   1   rising-edge clock, sole clock domain
//  rst            in   1   synchronous, active-low reset (sampled on clk rise)
//  A              out  8   counter_value[7:0]
//  B              out  8   counter_value[15:8]
//  C              out  8   current LFSR state
//  D              out  8   A ^ C
//  out            out  1   registered compare flag
//  counter_value  out  32  cycle counter
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset (rst==0 at a clk rise):
//  - cnt=0, lfsr=LFSR_SEED, out=0.
//  - Hence A=0, B=0, C=0xA5, D=0xA5.
//  - Applies mid-operation identically; held reset keeps these values.
//  Each clk rise with rst==1:
//  - cnt <= cnt+1, modulo 2^32.
//  - lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
//  - out <= ({1'b0,A}+{1'b0,B}) > ({1'b0,C}+{1'b0,D}).
//  Lane timing:
//  - A, B, C, D are combinational from the cnt/lfsr registers: zero latency.
//  - out lags A..D by exactly one cycle.
//  Compare rules:
//  - Sums are 9-bit, no truncation; compare is unsigned.
//  - Equal sums -> out=0.
//  LFSR sequence from seed: A5, EA, 75, 82, ... (period 255).
//  - Never reaches 0.
//  - Unaffected by counter wrap.
//  Counter wrap: 0xFFFFFFFF -> 0x00000000; A and B wrap with it; no flag.
//  No handshakes; outputs valid every cycle after the first reset.
// CONFIGURATION
//  QUEST_SATURATE_EN defined:
//  - counter saturates at 0xFFFFFFFF and holds.
//  - LFSR and out keep updating.
//  QUEST_SATURATE_EN undefined (default): counter wraps to 0.
// TESTING
//  1. rst=0 for 3 edges.
//     -> counter_value=0, A=0, B=0, C=A5, D=A5, out=0 each cycle.
//  2. Release rst, check edges 1,2,3.
//     -> counter 1,2,3; C=EA,75,82; D=EB,77,81; out=0,0,0.
//  3. Run 70000 cycles against a bit-exact reference model.
//     -> A/B/C/D/out match every cycle.
//     -> counter_value=70000; B increments when A wraps FF->00.
//  4. Assert rst=0 for one edge at cycle 500.
//     -> all outputs at reset values next cycle; sequence restarts as in test 2.
//  5. Force counter to 0xFFFFFFFE, run 3 edges.
//     -> default: FFFFFFFF, 0, 1.
//     -> with QUEST_SATURATE_EN: FFFFFFFF held.
//  6. LFSR_SEED=0 build, apply reset.
//     -> C=01 after reset; next edge C=B8; never 00.

Source files
------------

// File: rtl/quest.sv
// quest: free-running counter + Galois LFSR pattern source with lane compare flag.
// Optional QUEST_SATURATE_EN: counter saturates at all-ones instead of wrapping.
module quest #(
    parameter int         CNT_W     = 32,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter logic [7:0] LFSR_TAPS = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [7:0]       A,
    output logic [7:0]       B,
    output logic [7:0]       C,
    output logic [7:0]       D,
    output logic             out,
    output logic [CNT_W-1:0] counter_value
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_next;
    logic [15:0]      cnt_lo;
    logic [8:0]       sum_ab;
    logic [8:0]       sum_cd;
    logic             gt;

    if (CNT_W >= 16) begin : g_wide
        assign cnt_lo = cnt[15:0];
    end else begin : g_narrow
        assign cnt_lo = {{(16-CNT_W){1'b0}}, cnt};
    end

    always_comb begin
`ifdef QUEST_SATURATE_EN
        cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
`else
        cnt_next = cnt + CNT_W'(1);
`endif
    end

    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
    end

    assign A = cnt_lo[7:0];
    assign B = cnt_lo[15:8];
    assign C = lfsr;
    assign D = A ^ C;

    // Nine-bit sums keep the carry, so the compare never truncates.
    assign sum_ab = {1'b0, A} + {1'b0, B};
    assign sum_cd = {1'b0, C} + {1'b0, D};
    assign gt     = sum_ab > sum_cd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            lfsr <= SEED;
            out  <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            lfsr <= lfsr_next;
            out  <= gt;
        end
    end

    assign counter_value = cnt;

endmodule

// File: tb/tb_quest.sv
// tb_quest: directed and model-based checks for quest.
// Covers reset, release sequence, long run, mid-run reset, wrap and zero seed.
module tb_quest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst_s;
    logic [7:0]  A, B, C, D;
    logic        out;
    logic [31:0] counter_value;
    logic [7:0]  s_A, s_B, s_C, s_D;
    logic        s_out;
    logic [7:0]  s_cnt;
    logic [7:0]  z_A, z_B, z_C, z_D;
    logic        z_out;
    logic [31:0] z_cnt;

    quest dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D),
        .out(out), .counter_value(counter_value)
    );

    quest #(.CNT_W(8)) dut_s (
        .clk(clk), .rst(rst_s),
        .A(s_A), .B(s_B), .C(s_C), .D(s_D),
        .out(s_out), .counter_value(s_cnt)
    );

    quest #(.LFSR_SEED(8'h00)) dut_z (
        .clk(clk), .rst(rst),
        .A(z_A), .B(z_B), .C(z_C), .D(z_D),
        .out(z_out), .counter_value(z_cnt)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] m_cnt;
    logic [7:0]  m_lfsr;
    logic        m_out;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_main();
        logic [7:0] ma, mb, mc, md;
        ma = m_cnt[7:0];
        mb = m_cnt[15:8];
        mc = m_lfsr;
        md = ma ^ mc;
        chk("model_cnt", counter_value, m_cnt);
        chk("model_A", 32'(A), 32'(ma));
        chk("model_B", 32'(B), 32'(mb));
        chk("model_C", 32'(C), 32'(mc));
        chk("model_D", 32'(D), 32'(md));
        chk("model_out", 32'(out), 32'(m_out));
    endtask

    // One clock edge: advance the reference model, then sample.
    task automatic step();
        logic [8:0] sab, scd;
        @(posedge clk);
        if (!rst) begin
            m_cnt  = 32'h0;
            m_lfsr = 8'hA5;
            m_out  = 1'b0;
        end else begin
            sab = {1'b0, m_cnt[7:0]} + {1'b0, m_cnt[15:8]};
            scd = {1'b0, m_lfsr} + {1'b0, m_cnt[7:0] ^ m_lfsr};
            m_out = sab > scd;
`ifdef QUEST_SATURATE_EN
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`else
            m_cnt = m_cnt + 32'd1;
`endif
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
        end
        #1;
        check_main();
    endtask

    logic zero_seen;

    initial begin
        rst   = 1'b0;
        rst_s = 1'b0;
        m_cnt  = 32'h0;
        m_lfsr = 8'hA5;
        m_out  = 1'b0;

        // Held reset
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_cnt", counter_value, 32'h0);
            chk("rst_A", 32'(A), 32'h00);
            chk("rst_B", 32'(B), 32'h00);
            chk("rst_C", 32'(C), 32'hA5);
            chk("rst_D", 32'(D), 32'hA5);
            chk("rst_out", 32'(out), 32'h0);
        end

        // Release: first three edges
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("e1_cnt", counter_value, 32'd1);
        chk("e1_C", 32'(C), 32'hEA);
        chk("e1_D", 32'(D), 32'hEB);
        chk("e1_out", 32'(out), 32'h0);
        step();
        chk("e2_cnt", counter_value, 32'd2);
        chk("e2_C", 32'(C), 32'h75);
        chk("e2_D", 32'(D), 32'h77);
        chk("e2_out", 32'(out), 32'h0);
        step();
        chk("e3_cnt", counter_value, 32'd3);
        chk("e3_C", 32'(C), 32'h82);
        chk("e3_D", 32'(D), 32'h81);
        chk("e3_out", 32'(out), 32'h0);

        // Long run to 70000
        for (int i = 3; i < 70000; i++) step();
        chk("run_cnt", counter_value, 32'd70000);
        chk("run_A", 32'(A), 32'h70);
        chk("run_B", 32'(B), 32'h11);

        // Fresh start, then reset after 500 cycles
        @(negedge clk);
        rst = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 500; i++) step();
        chk("c500_cnt", counter_value, 32'd500);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("mid_cnt", counter_value, 32'h0);
        chk("mid_C", 32'(C), 32'hA5);
        chk("mid_D", 32'(D), 32'hA5);
        chk("mid_out", 32'(out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("mid_e1_C", 32'(C), 32'hEA);
        step();
        chk("mid_e2_C", 32'(C), 32'h75);
        step();
        chk("mid_e3_C", 32'(C), 32'h82);
        chk("mid_e3_cnt", counter_value, 32'd3);

        // Narrow counter instance: wrap (or saturate) at all-ones
        @(negedge clk);
        rst_s = 1'b1;
        for (int i = 0; i < 254; i++) step();
        chk("s_FE", 32'(s_cnt), 32'hFE);
        step();
        chk("s_w1", 32'(s_cnt), 32'hFF);
        chk("s_w1_A", 32'(s_A), 32'hFF);
        step();
`ifdef QUEST_SATURATE_EN
        chk("s_w2", 32'(s_cnt), 32'hFF);
        step();
        chk("s_w3", 32'(s_cnt), 32'hFF);
`else
        chk("s_w2", 32'(s_cnt), 32'h00);
        chk("s_w2_A", 32'(s_A), 32'h00);
        step();
        chk("s_w3", 32'(s_cnt), 32'h01);
`endif
        chk("s_B", 32'(s_B), 32'h00);

        // Zero-seed instance
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("z_rst_C", 32'(z_C), 32'h01);
        chk("z_rst_cnt", z_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("z_e1_C", 32'(z_C), 32'hB8);
        zero_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (z_C == 8'h00) zero_seen = 1'b1;
        end
        chk("z_nonzero", 32'(zero_seen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
